// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALU operations, write-back sources, flag bit positions and the strobe bundle.
package control_pkg;

    localparam int unsigned STATE_W   = 4;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned FLAGS_W   = 4;
    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned REG_SRC_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EXEC_R  = 4'd2,
        S_ALU_WB  = 4'd3,
        S_MEM_ADR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WB  = 4'd6,
        S_MEM_WR  = 4'd7,
        S_BRANCH  = 4'd8,
        S_LDI     = 4'd9,
        S_CMP     = 4'd10,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_LDI  = 4'h8;
    localparam logic [OP_W-1:0] OP_LDR  = 4'h9;
    localparam logic [OP_W-1:0] OP_STR  = 4'hA;
    localparam logic [OP_W-1:0] OP_B    = 4'hB;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'hC;
    localparam logic [OP_W-1:0] OP_BNE  = 4'hD;
    localparam logic [OP_W-1:0] OP_CMP  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_ORR = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;
    localparam logic [ALU_OP_W-1:0] ALU_MOV = 3'd5;
    localparam logic [ALU_OP_W-1:0] ALU_LSL = 3'd6;
    localparam logic [ALU_OP_W-1:0] ALU_LSR = 3'd7;

    localparam logic [REG_SRC_W-1:0] SRC_ALU = 2'd0;
    localparam logic [REG_SRC_W-1:0] SRC_MEM = 2'd1;
    localparam logic [REG_SRC_W-1:0] SRC_IMM = 2'd2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic                 adr_src;
        logic                 ir_write;
        logic                 pc_inc;
        logic                 pc_load;
        logic                 mem_write;
        logic                 reg_write;
        logic [REG_SRC_W-1:0] reg_src;
        logic [ALU_OP_W-1:0]  alu_op;
        logic                 alu_src_b;
        logic                 flags_write;
        logic                 halted;
    } ctrl_t;

    // Opcodes 0x0..0x7 are register ALU operations encoded directly in op[2:0].
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return ~op[OP_W-1];
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface multicycle_control_unit_if #(
    parameter int unsigned CNT_W = 8
);
    import control_pkg::*;

    logic [OP_W-1:0]      op;
    logic [FLAGS_W-1:0]   FLAGS;
    logic                 mem_ready;

    logic [STATE_W-1:0]   state;
    logic                 adr_src;
    logic                 ir_write;
    logic                 pc_inc;
    logic                 pc_load;
    logic                 mem_write;
    logic                 reg_write;
    logic [REG_SRC_W-1:0] reg_src;
    logic [ALU_OP_W-1:0]  alu_op;
    logic                 alu_src_b;
    logic                 flags_write;
    logic                 halted;
    logic [CNT_W-1:0]     instr_count;

    modport master (
        input  op, FLAGS, mem_ready,
        output state, adr_src, ir_write, pc_inc, pc_load, mem_write, reg_write,
               reg_src, alu_op, alu_src_b, flags_write, halted, instr_count
    );

    modport slave (
        output op, FLAGS, mem_ready,
        input  state, adr_src, ir_write, pc_inc, pc_load, mem_write, reg_write,
               reg_src, alu_op, alu_src_b, flags_write, halted, instr_count
    );

endinterface

// File: rtl/multicycle_control_unit_decoder.sv
// Combinational strobe decode from the current state; only FETCH strobes
// depend on mem_ready and only BRANCH looks at the flags.
module control_output_decoder
    import control_pkg::*;
(
    input  state_t             state,
    input  logic [OP_W-1:0]    op,
    input  logic [FLAGS_W-1:0] flags,
    input  logic               mem_ready,
    output ctrl_t              ctrl
);

    logic zero;
    logic unused_flags;

    assign zero         = flags[FLAG_Z];
    assign unused_flags = ^{flags[FLAG_N], flags[FLAG_C], flags[FLAG_V]};

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.adr_src  = 1'b0;
                ctrl.ir_write = mem_ready;
                ctrl.pc_inc   = mem_ready;
            end
            S_EXEC_R: begin
                ctrl.alu_op      = op[ALU_OP_W-1:0];
                ctrl.alu_src_b   = 1'b0;
                ctrl.flags_write = 1'b1;
            end
            S_ALU_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_src   = SRC_ALU;
            end
            S_LDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_src   = SRC_IMM;
            end
            S_MEM_ADR: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src_b = 1'b1;
            end
            S_MEM_RD: begin
                ctrl.adr_src = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_src   = SRC_MEM;
            end
            S_MEM_WR: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.pc_load = (op == OP_B)
                             | ((op == OP_BEQ) &  zero)
                             | ((op == OP_BNE) & ~zero);
            end
            S_CMP: begin
                ctrl.alu_op      = ALU_SUB;
                ctrl.alu_src_b   = 1'b0;
                ctrl.flags_write = 1'b1;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the 8-bit multicycle datapath: state register, next-state
// logic, retired-instruction counter and reset gating of all outputs.
module multicycle_control_unit
    import control_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    multicycle_control_unit_if.master  bus
);

    state_t            state_q;
    state_t            state_d;
    logic              retire_c;
    logic [CNT_W-1:0]  cnt_q;
    ctrl_t             ctrl_c;
    ctrl_t             ctrl_o;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (retire_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Next state; retire_c marks the edge that completes an instruction.
    always_comb begin
        state_d  = S_FETCH;
        retire_c = 1'b0;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (is_alu_op(bus.op)) begin
                    state_d = S_EXEC_R;
                end else begin
                    case (bus.op)
                        OP_LDI:                 state_d = S_LDI;
                        OP_LDR, OP_STR:         state_d = S_MEM_ADR;
                        OP_B, OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                        OP_CMP:                 state_d = S_CMP;
                        OP_HALT: begin
                            state_d  = S_HALT;
                            retire_c = 1'b1;
                        end
                        default:                state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC_R:  state_d = S_ALU_WB;
            S_MEM_ADR: state_d = (bus.op == OP_STR) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_d = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: begin
                state_d  = bus.mem_ready ? S_FETCH : S_MEM_WR;
                retire_c = bus.mem_ready;
            end
            S_ALU_WB, S_MEM_WB, S_LDI, S_BRANCH, S_CMP: begin
                state_d  = S_FETCH;
                retire_c = 1'b1;
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    control_output_decoder u_decoder (
        .state     (state_q),
        .op        (bus.op),
        .flags     (bus.FLAGS),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_c)
    );

    // Reset forces every output quiet in the same cycle, not just after the edge.
    assign ctrl_o          = reset ? '0 : ctrl_c;
    assign bus.state       = reset ? STATE_W'(S_FETCH) : STATE_W'(state_q);
    assign bus.instr_count = reset ? '0 : cnt_q;

    assign bus.adr_src     = ctrl_o.adr_src;
    assign bus.ir_write    = ctrl_o.ir_write;
    assign bus.pc_inc      = ctrl_o.pc_inc;
    assign bus.pc_load     = ctrl_o.pc_load;
    assign bus.mem_write   = ctrl_o.mem_write;
    assign bus.reg_write   = ctrl_o.reg_write;
    assign bus.reg_src     = ctrl_o.reg_src;
    assign bus.alu_op      = ctrl_o.alu_op;
    assign bus.alu_src_b   = ctrl_o.alu_src_b;
    assign bus.flags_write = ctrl_o.flags_write;
    assign bus.halted      = ctrl_o.halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: per-instruction state sequences and strobes derived
// from the instruction class, with random opcodes, flags and wait states.
module tb_multicycle_control_unit;

    localparam int unsigned CNT_W = 8;

    logic clock = 1'b0;
    logic reset;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned exp_cnt = 0;

    multicycle_control_unit_if #(.CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(.CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] dut_strobes();
        return {bus.adr_src, bus.ir_write, bus.pc_inc, bus.pc_load, bus.mem_write,
                bus.reg_write, bus.reg_src, bus.alu_op, bus.alu_src_b,
                bus.flags_write, bus.halted};
    endfunction

    // Expected strobes for a state, straight from the per-state output table.
    function automatic logic [13:0] exp_strobes(input int st, input logic [3:0] o,
                                                input logic [3:0] f, input logic mr);
        logic adr = 0, ir = 0, pci = 0, pcl = 0, mw = 0, rw = 0, fw = 0, asb = 0, h = 0;
        logic [1:0] rs = 0;
        logic [2:0] ao = 0;
        case (st)
            0:  begin ir = mr; pci = mr; end
            2:  begin ao = o[2:0]; fw = 1; end
            3:  rw = 1;
            4:  begin ao = 3'd0; asb = 1; end
            5:  adr = 1;
            6:  begin rw = 1; rs = 2'd1; end
            7:  begin adr = 1; mw = 1; end
            8:  pcl = (o == 4'hB) || (o == 4'hC && f[2]) || (o == 4'hD && !f[2]);
            9:  begin rw = 1; rs = 2'd2; end
            10: begin ao = 3'd1; fw = 1; end
            15: h = 1;
            default: ;
        endcase
        return {adr, ir, pci, pcl, mw, rw, rs, ao, asb, fw, h};
    endfunction

    // Called at a falling edge: drive inputs, check this cycle, move to next falling edge.
    task automatic step(input int st, input logic mr, input logic [3:0] o, input logic [3:0] f);
        bus.mem_ready = mr;
        bus.op        = o;
        bus.FLAGS     = f;
        #1;
        check($sformatf("state(exp %0d)", st), 32'(bus.state), 32'(st));
        check($sformatf("strobes(st %0d op %0h)", st, o), 32'(dut_strobes()),
              32'(exp_strobes(st, o, f, mr)));
        check("instr_count", 32'(bus.instr_count), 32'(exp_cnt % 256));
        @(negedge clock);
    endtask

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    function automatic logic [3:0] rnib();
        return 4'($urandom);
    endfunction

    // One instruction: fetch waits, decode, then the class-specific state path.
    task automatic run_instr(input logic [3:0] o, input logic [3:0] f, input int fwait, input int mwait);
        for (int i = 0; i < fwait; i++) step(0, 1'b0, rnib(), rnib());
        step(0, 1'b1, rnib(), rnib());
        step(1, rbit(), o, rnib());
        if (o < 4'h8) begin
            step(2, rbit(), o, rnib());
            step(3, rbit(), o, rnib());
        end else if (o == 4'h8) begin
            step(9, rbit(), o, rnib());
        end else if (o == 4'h9) begin
            step(4, rbit(), o, rnib());
            for (int i = 0; i < mwait; i++) step(5, 1'b0, o, rnib());
            step(5, 1'b1, o, rnib());
            step(6, rbit(), o, rnib());
        end else if (o == 4'hA) begin
            step(4, rbit(), o, rnib());
            for (int i = 0; i < mwait; i++) step(7, 1'b0, o, rnib());
            step(7, 1'b1, o, rnib());
        end else if (o <= 4'hD) begin
            step(8, rbit(), o, f);
        end else if (o == 4'hE) begin
            step(10, rbit(), o, rnib());
        end
        if (o == 4'hF) begin
            exp_cnt++;
            step(15, rbit(), o, rnib());
        end else begin
            exp_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clock);
        #1;
        check("reset state", 32'(bus.state), 32'd0);
        check("reset strobes", 32'(dut_strobes()), 32'd0);
        check("reset count", 32'(bus.instr_count), 32'd0);
        exp_cnt = 0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.op = 4'h0;
        bus.FLAGS = 4'h0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("reset state", 32'(bus.state), 32'd0);
        check("reset strobes", 32'(dut_strobes()), 32'd0);
        check("reset count", 32'(bus.instr_count), 32'd0);
        reset = 1'b0;

        // ALU ADD, LDR with two read waits, then both branch polarities.
        run_instr(4'h0, 4'h0, 0, 0);
        run_instr(4'h9, 4'h0, 0, 2);
        run_instr(4'hC, 4'b0100, 0, 0);
        run_instr(4'hC, 4'b0000, 0, 0);
        run_instr(4'hD, 4'b0100, 0, 0);
        run_instr(4'hD, 4'b0000, 0, 0);
        run_instr(4'hB, 4'b0100, 1, 0);
        run_instr(4'hA, 4'h0, 2, 3);

        // Random instruction stream, HALT excluded.
        for (int n = 0; n < 300; n++) begin
            run_instr(4'($urandom_range(0, 14)), rnib(), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 2)));
        end

        // 256 LDIs wrap the 8-bit counter back to 0.
        do_reset();
        for (int n = 0; n < 256; n++) run_instr(4'h8, rnib(), 0, 0);
        check("count wrap", 32'(bus.instr_count), 32'd0);

        // Reset in the middle of a stalled store.
        run_instr(4'h1, 4'h0, 0, 0);
        step(0, 1'b1, rnib(), rnib());
        step(1, 1'b0, 4'hA, rnib());
        step(4, 1'b0, 4'hA, rnib());
        step(7, 1'b0, 4'hA, rnib());
        step(7, 1'b0, 4'hA, rnib());
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        check("mid-reset state", 32'(bus.state), 32'd0);
        check("mid-reset mem_write", 32'(bus.mem_write), 32'd0);
        @(negedge clock);
        #1;
        check("post-reset state", 32'(bus.state), 32'd0);
        check("post-reset mem_write", 32'(bus.mem_write), 32'd0);
        check("post-reset count", 32'(bus.instr_count), 32'd0);
        exp_cnt = 0;
        reset = 1'b0;
        run_instr(4'h6, 4'h0, 1, 0);

        // HALT is absorbing and freezes the counter.
        run_instr(4'hF, 4'h0, 0, 0);
        for (int n = 0; n < 20; n++) step(15, rbit(), rnib(), rnib());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
